// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - MIPS decode stage with ID/EX register, WB bypass, load-use and flush handling
//
// Purpose:
//   Decodes the instruction held in IF/ID, reads the register file (with an
//   optional same-cycle write-back bypass), and loads the result into the
//   ID/EX pipeline register. Inserts a bubble on a load-use hazard or on a
//   branch/jump flush. A flush that arrives while EX is held is remembered
//   and applied on the first un-held edge. Stall and flush events are counted
//   in saturating counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instrD, pcD, pcplus4D     instruction in decode and its PC / PC+4
//   regwriteW, rdW, resultW   register file write-back port
//   flushD                    squash the decode instruction (taken branch/jump)
//   holdE                     downstream hold; ID/EX keeps its contents
//   stallD                    combinational hold request to fetch and IF/ID
//   validE                    ID/EX holds a real instruction (0 = bubble)
//   regwriteE .. jumpE        registered control bits
//   alusignalE                registered ALU control
//   op1E, op2E, immxE         registered operands and sign-extended immediate
//   jumpoffset                registered jump target
//   rdE, rs1E, rs2E           registered register addresses
//   pcE, pcplus4E             registered PCs
//   perf_stalls, perf_flushes saturating stall / flush cycle counters
module decode_stage_hz #(
    parameter int XLEN            = 32,
    parameter int WB_BYPASS       = 1,
    parameter int LOAD_USE_DETECT = 1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instrD,
    input  logic [XLEN-1:0]  pcD,
    input  logic [XLEN-1:0]  pcplus4D,
    input  logic             regwriteW,
    input  logic [4:0]       rdW,
    input  logic [XLEN-1:0]  resultW,
    input  logic             flushD,
    input  logic             holdE,
    output logic             stallD,
    output logic             validE,
    output logic             regwriteE,
    output logic             isimmediateE,
    output logic             memwriteE,
    output logic             isloadE,
    output logic             memreadE,
    output logic             branchE,
    output logic             jumpE,
    output logic [3:0]       alusignalE,
    output logic [XLEN-1:0]  op1E,
    output logic [XLEN-1:0]  op2E,
    output logic [XLEN-1:0]  immxE,
    output logic [XLEN-1:0]  jumpoffset,
    output logic [4:0]       rdE,
    output logic [4:0]       rs1E,
    output logic [4:0]       rs2E,
    output logic [XLEN-1:0]  pcE,
    output logic [XLEN-1:0]  pcplus4E,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Main-decoder to ALU-decoder selector
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;
    localparam logic [1:0] AOP_IMM   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            isimm;
        logic            memwrite;
        logic            isload;
        logic            memread;
        logic            branch;
        logic            jump;
        logic [3:0]      alu;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] immx;
        logic [XLEN-1:0] joff;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
    } idex_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = instrD[31:26];
    assign funct  = instrD[5:0];
    assign rs1    = instrD[25:21];
    assign rs2    = instrD[20:16];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       dec_regdest;
    logic       dec_regwrite;
    logic       dec_isimm;
    logic       dec_memwrite;
    logic       dec_isload;
    logic       dec_memread;
    logic       dec_branch;
    logic       dec_jump;
    logic [1:0] dec_aluop;
    logic [3:0] dec_alu;

    always_comb begin
        dec_regdest  = 1'b0;
        dec_regwrite = 1'b0;
        dec_isimm    = 1'b0;
        dec_memwrite = 1'b0;
        dec_isload   = 1'b0;
        dec_memread  = 1'b0;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_aluop    = AOP_ADD;
        case (opcode)
            OP_RTYPE: begin
                dec_regdest  = 1'b1;
                dec_regwrite = 1'b1;
                dec_aluop    = AOP_FUNCT;
            end
            OP_LW: begin
                dec_regwrite = 1'b1;
                dec_isimm    = 1'b1;
                dec_isload   = 1'b1;
                dec_memread  = 1'b1;
            end
            OP_SW: begin
                dec_isimm    = 1'b1;
                dec_memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec_branch   = 1'b1;
                dec_aluop    = AOP_SUB;
            end
            OP_ADDI: begin
                dec_regwrite = 1'b1;
                dec_isimm    = 1'b1;
            end
            OP_SLTI, OP_ANDI, OP_ORI: begin
                dec_regwrite = 1'b1;
                dec_isimm    = 1'b1;
                dec_aluop    = AOP_IMM;
            end
            OP_J: begin
                dec_jump     = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        dec_alu = ALU_ADD;
        case (dec_aluop)
            AOP_SUB: dec_alu = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    FN_ADD:  dec_alu = ALU_ADD;
                    FN_SUB:  dec_alu = ALU_SUB;
                    FN_AND:  dec_alu = ALU_AND;
                    FN_OR:   dec_alu = ALU_OR;
                    FN_NOR:  dec_alu = ALU_NOR;
                    FN_SLT:  dec_alu = ALU_SLT;
                    default: dec_alu = ALU_ADD;
                endcase
            end
            AOP_IMM: begin
                case (opcode)
                    OP_ANDI: dec_alu = ALU_AND;
                    OP_ORI:  dec_alu = ALU_OR;
                    OP_SLTI: dec_alu = ALU_SLT;
                    default: dec_alu = ALU_ADD;
                endcase
            end
            default: dec_alu = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rd1_val;
    logic [XLEN-1:0] rd2_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (regwriteW && (rdW != 5'd0)) begin
            rf_q[rdW] <= resultW;
        end
    end

    // r0 is forced to zero on read so it never reflects a write-back to it.
    always_comb begin
        rd1_val = rf_q[rs1];
        if (rs1 == 5'd0) begin
            rd1_val = '0;
        end else if ((WB_BYPASS != 0) && regwriteW && (rdW == rs1)) begin
            rd1_val = resultW;
        end
    end

    always_comb begin
        rd2_val = rf_q[rs2];
        if (rs2 == 5'd0) begin
            rd2_val = '0;
        end else if ((WB_BYPASS != 0) && regwriteW && (rdW == rs2)) begin
            rd2_val = resultW;
        end
    end

    // ------------------------------------------------------------------
    // Hazards and ID/EX register
    // ------------------------------------------------------------------
    idex_t idex_q;
    idex_t idex_d;
    idex_t dec_fields;
    logic  flush_pend_q;
    logic  flush_pend_d;
    logic  luse;
    logic  eff_flush;

    assign luse = (LOAD_USE_DETECT != 0) && idex_q.valid && idex_q.isload
                  && (idex_q.rd != 5'd0)
                  && ((idex_q.rd == rs1) || (idex_q.rd == rs2));

    // A flush seen under hold is applied on the first un-held edge.
    assign eff_flush = (flushD || flush_pend_q) && !holdE;

    // A squashed decode instruction never needs to wait for its load.
    assign stallD = holdE || (luse && !eff_flush);

    always_comb begin
        dec_fields          = '0;
        dec_fields.valid    = 1'b1;
        dec_fields.regwrite = dec_regwrite;
        dec_fields.isimm    = dec_isimm;
        dec_fields.memwrite = dec_memwrite;
        dec_fields.isload   = dec_isload;
        dec_fields.memread  = dec_memread;
        dec_fields.branch   = dec_branch;
        dec_fields.jump     = dec_jump;
        dec_fields.alu      = dec_alu;
        dec_fields.op1      = rd1_val;
        dec_fields.op2      = rd2_val;
        dec_fields.immx     = {{(XLEN-16){instrD[15]}}, instrD[15:0]};
        dec_fields.joff[31:0] = {pcplus4D[31:28], instrD[25:0], 2'b00};
        dec_fields.rd       = dec_regdest ? instrD[15:11] : instrD[20:16];
        dec_fields.rs1      = rs1;
        dec_fields.rs2      = rs2;
        dec_fields.pc       = pcD;
        dec_fields.pcplus4  = pcplus4D;
    end

    always_comb begin
        idex_d       = idex_q;
        flush_pend_d = flush_pend_q;
        if (holdE) begin
            flush_pend_d = flush_pend_q || flushD;
        end else begin
            idex_d       = dec_fields;
            flush_pend_d = 1'b0;
            // Bubble: kill every side-effecting field; data fields are don't-care.
            if (eff_flush || luse) begin
                idex_d.valid    = 1'b0;
                idex_d.regwrite = 1'b0;
                idex_d.memwrite = 1'b0;
                idex_d.memread  = 1'b0;
                idex_d.isload   = 1'b0;
                idex_d.branch   = 1'b0;
                idex_d.jump     = 1'b0;
                idex_d.rd       = 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            idex_q       <= idex_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] perf_stalls_q;
    logic [CNT_W-1:0] perf_stalls_d;
    logic [CNT_W-1:0] perf_flushes_q;
    logic [CNT_W-1:0] perf_flushes_d;

    always_comb begin
        perf_stalls_d  = perf_stalls_q;
        perf_flushes_d = perf_flushes_q;
        if (stallD && (perf_stalls_q != CNT_MAX)) begin
            perf_stalls_d = perf_stalls_q + CNT_W'(1);
        end
        if (eff_flush && (perf_flushes_q != CNT_MAX)) begin
            perf_flushes_d = perf_flushes_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stalls_q  <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign validE       = idex_q.valid;
    assign regwriteE    = idex_q.regwrite;
    assign isimmediateE = idex_q.isimm;
    assign memwriteE    = idex_q.memwrite;
    assign isloadE      = idex_q.isload;
    assign memreadE     = idex_q.memread;
    assign branchE      = idex_q.branch;
    assign jumpE        = idex_q.jump;
    assign alusignalE   = idex_q.alu;
    assign op1E         = idex_q.op1;
    assign op2E         = idex_q.op2;
    assign immxE        = idex_q.immx;
    assign jumpoffset   = idex_q.joff;
    assign rdE          = idex_q.rd;
    assign rs1E         = idex_q.rs1;
    assign rs2E         = idex_q.rs2;
    assign pcE          = idex_q.pc;
    assign pcplus4E     = idex_q.pcplus4;
    assign perf_stalls  = perf_stalls_q;
    assign perf_flushes = perf_flushes_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb/tb_decode_stage_hz.sv - testbench for decode_stage_hz
module tb_decode_stage_hz;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [31:0] instrD = '0;
    logic [31:0] pcD = '0;
    logic [31:0] pcplus4D = '0;
    logic        regwriteW = 1'b0;
    logic [4:0]  rdW = '0;
    logic [31:0] resultW = '0;
    logic        flushD = 1'b0;
    logic        holdE = 1'b0;

    // Instance 0: defaults, 1: WB_BYPASS=0, 2: CNT_W=2
    logic        stallD [3];
    logic        validE [3];
    logic        regwriteE [3];
    logic        isimmediateE [3];
    logic        memwriteE [3];
    logic        isloadE [3];
    logic        memreadE [3];
    logic        branchE [3];
    logic        jumpE [3];
    logic [3:0]  alusignalE [3];
    logic [31:0] op1E [3];
    logic [31:0] op2E [3];
    logic [31:0] immxE [3];
    logic [31:0] jumpoffset [3];
    logic [4:0]  rdE [3];
    logic [4:0]  rs1E [3];
    logic [4:0]  rs2E [3];
    logic [31:0] pcE [3];
    logic [31:0] pcplus4E [3];
    logic [15:0] ps0, pf0, ps1, pf1;
    logic [1:0]  ps2, pf2;

    decode_stage_hz #(.XLEN(32), .WB_BYPASS(1), .LOAD_USE_DETECT(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
        .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .flushD(flushD), .holdE(holdE),
        .stallD(stallD[0]), .validE(validE[0]), .regwriteE(regwriteE[0]),
        .isimmediateE(isimmediateE[0]), .memwriteE(memwriteE[0]), .isloadE(isloadE[0]),
        .memreadE(memreadE[0]), .branchE(branchE[0]), .jumpE(jumpE[0]),
        .alusignalE(alusignalE[0]), .op1E(op1E[0]), .op2E(op2E[0]), .immxE(immxE[0]),
        .jumpoffset(jumpoffset[0]), .rdE(rdE[0]), .rs1E(rs1E[0]), .rs2E(rs2E[0]),
        .pcE(pcE[0]), .pcplus4E(pcplus4E[0]), .perf_stalls(ps0), .perf_flushes(pf0));

    decode_stage_hz #(.XLEN(32), .WB_BYPASS(0), .LOAD_USE_DETECT(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
        .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .flushD(flushD), .holdE(holdE),
        .stallD(stallD[1]), .validE(validE[1]), .regwriteE(regwriteE[1]),
        .isimmediateE(isimmediateE[1]), .memwriteE(memwriteE[1]), .isloadE(isloadE[1]),
        .memreadE(memreadE[1]), .branchE(branchE[1]), .jumpE(jumpE[1]),
        .alusignalE(alusignalE[1]), .op1E(op1E[1]), .op2E(op2E[1]), .immxE(immxE[1]),
        .jumpoffset(jumpoffset[1]), .rdE(rdE[1]), .rs1E(rs1E[1]), .rs2E(rs2E[1]),
        .pcE(pcE[1]), .pcplus4E(pcplus4E[1]), .perf_stalls(ps1), .perf_flushes(pf1));

    decode_stage_hz #(.XLEN(32), .WB_BYPASS(1), .LOAD_USE_DETECT(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D),
        .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .flushD(flushD), .holdE(holdE),
        .stallD(stallD[2]), .validE(validE[2]), .regwriteE(regwriteE[2]),
        .isimmediateE(isimmediateE[2]), .memwriteE(memwriteE[2]), .isloadE(isloadE[2]),
        .memreadE(memreadE[2]), .branchE(branchE[2]), .jumpE(jumpE[2]),
        .alusignalE(alusignalE[2]), .op1E(op1E[2]), .op2E(op2E[2]), .immxE(immxE[2]),
        .jumpoffset(jumpoffset[2]), .rdE(rdE[2]), .rs1E(rs1E[2]), .rs2E(rs2E[2]),
        .pcE(pcE[2]), .pcplus4E(pcplus4E[2]), .perf_stalls(ps2), .perf_flushes(pf2));

    typedef struct packed {
        logic        valid;
        logic [6:0]  ctrl;   // regwrite,isimm,memwrite,isload,memread,branch,jump
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] joff;
        logic [31:0] pc;
        logic [31:0] pc4;
    } snap_t;

    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] mdl [32];
    logic [31:0] pc_v = 32'h4000_0000;
    snap_t       exp_q [$];
    snap_t       e_s;
    snap_t       o_s;
    snap_t       last_e;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && regwriteW && (rdW == a)) return resultW;
        return mdl[a];
    endfunction

    function automatic snap_t expect_dec(input logic [31:0] ins, input bit byp);
        snap_t s;
        s       = '0;
        s.valid = 1'b1;
        case (ins[31:26])
            6'h00: begin
                s.ctrl = 7'b1000000;
                s.rd   = ins[15:11];
                s.alu  = (ins[5:0] == 6'h22) ? 4'b0110 : 4'b0010;
            end
            6'h23: begin
                s.ctrl = 7'b1101100;
                s.rd   = ins[20:16];
                s.alu  = 4'b0010;
            end
            default: begin
                s.ctrl = 7'b0000000;
                s.rd   = ins[20:16];
                s.alu  = 4'b0010;
            end
        endcase
        s.rs1  = ins[25:21];
        s.rs2  = ins[20:16];
        s.op1  = rd_model(ins[25:21], byp);
        s.op2  = rd_model(ins[20:16], byp);
        s.imm  = {{16{ins[15]}}, ins[15:0]};
        s.joff = {pcplus4D[31:28], ins[25:0], 2'b00};
        s.pc   = pcD;
        s.pc4  = pcplus4D;
        return s;
    endfunction

    function automatic snap_t bubble(input snap_t s);
        snap_t b;
        b       = s;
        b.valid = 1'b0;
        b.ctrl  = s.ctrl & 7'b0100000;
        b.rd    = 5'd0;
        return b;
    endfunction

    function automatic snap_t obs(input int k);
        snap_t s;
        s.valid = validE[k];
        s.ctrl  = {regwriteE[k], isimmediateE[k], memwriteE[k], isloadE[k],
                   memreadE[k], branchE[k], jumpE[k]};
        s.alu   = alusignalE[k];
        s.rd    = rdE[k];
        s.rs1   = rs1E[k];
        s.rs2   = rs2E[k];
        s.op1   = op1E[k];
        s.op2   = op2E[k];
        s.imm   = immxE[k];
        s.joff  = jumpoffset[k];
        s.pc    = pcE[k];
        s.pc4   = pcplus4E[k];
        return s;
    endfunction

    task automatic drive(input logic [31:0] ins);
        instrD   = ins;
        pcD      = pc_v;
        pcplus4D = pc_v + 32'd4;
        pc_v     = pc_v + 32'd4;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        end else if (regwriteW && (rdW != 5'd0)) begin
            mdl[rdW] = resultW;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            instrD    = $urandom;
            pcD       = $urandom;
            pcplus4D  = $urandom;
            regwriteW = 1'b1;
            rdW       = 5'($urandom_range(1, 31));
            resultW   = $urandom;
            flushD    = 1'b1;
            holdE     = 1'($urandom_range(0, 1));
            tick();
        end
        holdE     = 1'b0;
        flushD    = 1'b0;
        regwriteW = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            o_s = obs(k);
            nchk++;
            if (o_s !== '0) begin
                nerr++;
                $display("FAIL reset_outputs inst=%0d got=%h exp=0", k, o_s);
            end
            nchk++;
            if (stallD[k] !== 1'b0) begin
                nerr++;
                $display("FAIL reset_stallD inst=%0d got=%b exp=0", k, stallD[k]);
            end
        end
        nchk++;
        if ({ps0, pf0, ps2, pf2} !== '0) begin
            nerr++;
            $display("FAIL reset_counters got=%h/%h/%h/%h exp=0", ps0, pf0, ps2, pf2);
        end
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        logic [31:0] e1;
        regwriteW = 1'b1;
        rdW = 5'd1; resultW = 32'h0000_0100; drive(32'h0); tick();
        rdW = 5'd2; resultW = 32'h0000_0022; drive(32'h0); tick();
        rdW = 5'd5; resultW = 32'h0000_0055; drive(32'h0); tick();
        // Write r5 and read it in the same cycle.
        rdW = 5'd5; resultW = 32'hDEAD_BEEF;
        drive(r_type(5'd5, 5'd0, 5'd6, 6'h20));
        exp_q.push_back(expect_dec(instrD, 1'b1));
        e1 = rd_model(5'd5, 1'b0);
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL bypass_same_cycle got=%h exp=%h", o_s, e_s); end
        nchk++;
        if (op1E[1] !== e1) begin nerr++; $display("FAIL nobypass_old got=%h exp=%h", op1E[1], e1); end
        // Next cycle both builds see the written value.
        regwriteW = 1'b0;
        drive(r_type(5'd5, 5'd0, 5'd6, 6'h20));
        exp_q.push_back(expect_dec(instrD, 1'b1));
        e1 = rd_model(5'd5, 1'b0);
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL bypass_next got=%h exp=%h", o_s, e_s); end
        nchk++;
        if (op1E[1] !== e1) begin nerr++; $display("FAIL nobypass_next got=%h exp=%h", op1E[1], e1); end
    endtask

    task automatic test_r0();
        regwriteW = 1'b1; rdW = 5'd0; resultW = 32'h0000_1234;
        drive(r_type(5'd0, 5'd0, 5'd6, 6'h20));
        exp_q.push_back(expect_dec(instrD, 1'b1));
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL r0_bypass got=%h exp=%h", o_s, e_s); end
        regwriteW = 1'b0;
        drive(r_type(5'd0, 5'd0, 5'd6, 6'h20));
        exp_q.push_back(expect_dec(instrD, 1'b1));
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL r0_read got=%h exp=%h", o_s, e_s); end
        nchk++;
        if (op1E[1] !== 32'd0) begin nerr++; $display("FAIL r0_nobypass got=%h exp=0", op1E[1]); end
    endtask

    task automatic test_load_use();
        drive(i_type(6'h23, 5'd1, 5'd8, 16'hFFFC));
        exp_q.push_back(expect_dec(instrD, 1'b1));
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL lu_load got=%h exp=%h", o_s, e_s); end
        drive(r_type(5'd8, 5'd2, 5'd9, 6'h20));
        #1;
        nchk++;
        if (stallD[0] !== 1'b1) begin nerr++; $display("FAIL lu_stall got=%b exp=1", stallD[0]); end
        exp_q.push_back(bubble(expect_dec(instrD, 1'b1)));
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL lu_bubble got=%h exp=%h", o_s, e_s); end
        nchk++;
        if (stallD[0] !== 1'b0) begin nerr++; $display("FAIL lu_stall_drop got=%b exp=0", stallD[0]); end
        // IF/ID held, so the same add is presented again.
        exp_q.push_back(expect_dec(instrD, 1'b1));
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        last_e = e_s;
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL lu_issue got=%h exp=%h", o_s, e_s); end
        nchk++;
        if (ps0 !== 16'd1 || ps2 !== 2'd1) begin
            nerr++; $display("FAIL lu_perf got=%0d/%0d exp=1/1", ps0, ps2);
        end
    endtask

    task automatic test_flush_hold();
        drive(r_type(5'd9, 5'd2, 5'd10, 6'h22));
        holdE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flushD = (c == 0) || (c == 2);
            exp_q.push_back(last_e);
            #1;
            nchk++;
            if (stallD[0] !== 1'b1) begin nerr++; $display("FAIL fh_stall c=%0d got=%b exp=1", c, stallD[0]); end
            tick();
            e_s = exp_q.pop_front(); o_s = obs(0);
            nchk++;
            if (o_s !== e_s) begin nerr++; $display("FAIL fh_hold c=%0d got=%h exp=%h", c, o_s, e_s); end
        end
        holdE  = 1'b0;
        flushD = 1'b0;
        exp_q.push_back(bubble(expect_dec(instrD, 1'b1)));
        #1;
        nchk++;
        if (stallD[0] !== 1'b0) begin nerr++; $display("FAIL fh_release_stall got=%b exp=0", stallD[0]); end
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL fh_bubble got=%h exp=%h", o_s, e_s); end
        drive(r_type(5'd1, 5'd2, 5'd11, 6'h20));
        exp_q.push_back(expect_dec(instrD, 1'b1));
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL fh_single_flush got=%h exp=%h", o_s, e_s); end
        nchk++;
        if (pf0 !== 16'd1 || ps0 !== 16'd4 || ps2 !== 2'd3) begin
            nerr++; $display("FAIL fh_perf got=%0d/%0d/%0d exp=1/4/3", pf0, ps0, ps2);
        end
    endtask

    task automatic test_priority();
        drive(i_type(6'h23, 5'd1, 5'd8, 16'h0000));
        exp_q.push_back(expect_dec(instrD, 1'b1));
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL prio_load got=%h exp=%h", o_s, e_s); end
        drive(r_type(5'd8, 5'd2, 5'd9, 6'h20));
        flushD = 1'b1;
        #1;
        nchk++;
        if (stallD[0] !== 1'b0) begin nerr++; $display("FAIL prio_stall got=%b exp=0", stallD[0]); end
        exp_q.push_back(bubble(expect_dec(instrD, 1'b1)));
        tick();
        flushD = 1'b0;
        e_s = exp_q.pop_front(); o_s = obs(0);
        last_e = e_s;
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL prio_bubble got=%h exp=%h", o_s, e_s); end
        nchk++;
        if (ps0 !== 16'd4 || pf0 !== 16'd2) begin
            nerr++; $display("FAIL prio_perf got=%0d/%0d exp=4/2", ps0, pf0);
        end
    endtask

    task automatic test_saturation();
        holdE = 1'b1;
        drive(r_type(5'd1, 5'd1, 5'd12, 6'h20));
        exp_q.push_back(last_e);
        repeat (6) tick();
        holdE = 1'b0;
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL sat_hold got=%h exp=%h", o_s, e_s); end
        nchk++;
        if (ps2 !== 2'd3) begin nerr++; $display("FAIL sat_cnt2 got=%0d exp=3", ps2); end
        nchk++;
        if (ps0 !== 16'd10) begin nerr++; $display("FAIL sat_cnt16 got=%0d exp=10", ps0); end
    endtask

    task automatic test_reset_mid();
        holdE  = 1'b1;
        flushD = 1'b1;
        drive(r_type(5'd5, 5'd0, 5'd6, 6'h20));
        tick();
        flushD = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        holdE  = 1'b0;
        #1;
        o_s = obs(0);
        nchk++;
        if (o_s !== '0) begin nerr++; $display("FAIL rmid_outputs got=%h exp=0", o_s); end
        nchk++;
        if (stallD[0] !== 1'b0) begin nerr++; $display("FAIL rmid_stall got=%b exp=0", stallD[0]); end
        nchk++;
        if (ps0 !== 16'd0 || pf0 !== 16'd0) begin
            nerr++; $display("FAIL rmid_counters got=%0d/%0d exp=0/0", ps0, pf0);
        end
        drive(r_type(5'd5, 5'd0, 5'd6, 6'h20));
        exp_q.push_back(expect_dec(instrD, 1'b1));
        tick();
        e_s = exp_q.pop_front(); o_s = obs(0);
        nchk++;
        if (o_s !== e_s) begin nerr++; $display("FAIL rmid_no_pending got=%h exp=%h", o_s, e_s); end
        nchk++;
        if (pf0 !== 16'd0) begin nerr++; $display("FAIL rmid_flush_cnt got=%0d exp=0", pf0); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        test_reset();
        test_bypass();
        test_r0();
        test_load_use();
        test_flush_hold();
        test_priority();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised instruction-decode stage with an integrated ID/EX pipeline register for the 5-stage MIPS pipeline. It sits between fetch and execute. Like the existing decode stage, it decodes the instruction, reads the register file, sign-extends the immediate and forms the jump target. It adds:
- a write-back bypass,
- load-use hazard detection with bubble insertion,
- branch/jump flush with deferral under downstream hold,
- saturating stall/flush performance counters.

## Interface
Parameters:
- XLEN, 32, datapath/PC width (≥32); immediates sign-extended to XLEN, jump target zero-extended.
- WB_BYPASS, 1, 1 = register read returns same-cycle write-back data.
- LOAD_USE_DETECT, 1, 1 = internal load-use stall enabled; 0 = stallD driven only by holdE.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- instrD  in  32  instruction in decode.
- pcD, pcplus4D  in  XLEN  PC and PC+4 of instrD.
- regwriteW  in  1  write-back enable.
- rdW  in  5  write-back register.
- resultW  in  XLEN  write-back data.
- flushD  in  1  taken branch/jump resolved in EX; squash instrD.
- holdE  in  1  downstream stall; ID/EX must hold.
- stallD  out  1  combinational; fetch and IF/ID must hold this cycle.
- validE  out  1  ID/EX holds a real instruction (0 = bubble).
- regwriteE, isimmediateE, memwriteE, isloadE, memreadE, branchE, jumpE  out  1 each  registered control.
- alusignalE  out  4  registered ALU control.
- op1E, op2E, immxE, jumpoffset  out  XLEN  registered operands, immediate, jump target.
- rdE, rs1E, rs2E  out  5  registered register addresses.
- pcE, pcplus4E  out  XLEN  registered PCs.
- perf_stalls, perf_flushes  out  CNT_W  saturating event counters.

## Operation
- Decode: opcode/funct → control and alusignal, using the team's existing control-unit and ALU-control encodings.
  - rd = instrD[15:11] if RegDest, else instrD[20:16].
  - rs1 = [25:21], rs2 = [20:16].
  - immx = sext(instrD[15:0]).
  - jumpoffset = {pcplus4D[31:28], instrD[25:0], 2'b00}.
- Register file:
  - 32×XLEN; r0 reads 0 and ignores writes.
  - Written at posedge when regwriteW && rdW≠0; rst clears all entries.
  - Read combinational. If WB_BYPASS && regwriteW && rdW==rsX && rsX≠0, the read returns resultW.
- Load-use: luse = LOAD_USE_DETECT && validE && isloadE && rdE≠0 && (rdE==rs1 || rdE==rs2).
- flush_pend register:
  - Set when flushD && holdE.
  - Cleared when applied or on rst.
  - eff_flush = (flushD || flush_pend) && !holdE.
- ID/EX update priority at each posedge:
  1. rst: all outputs 0, validE=0.
  2. holdE: all ID/EX fields unchanged.
  3. eff_flush: bubble; flush_pend←0.
  4. luse: bubble.
  5. Otherwise load decoded fields, validE=1.
- Bubble: validE, regwriteE, memwriteE, memreadE, isloadE, branchE, jumpE, rdE ← 0. Other data fields load normally (don't-care).
- stallD = holdE || (luse && !eff_flush). No stall is raised when the decode instruction is being squashed.
- Counters: both cleared by rst, saturate at 2^CNT_W−1, and count one per cycle while !rst.
  - perf_stalls increments every cycle stallD=1.
  - perf_flushes increments every cycle eff_flush=1.

## Timing
- Decode-to-execute latency: 1 cycle (instrD at edge N appears on *E outputs after edge N).
- Register write at edge N:
  - With WB_BYPASS=1, a same-cycle read already sees resultW.
  - With WB_BYPASS=0, the new value is visible from cycle N+1.
- Load-use: one bubble per load-use pair. stallD is high exactly one cycle, provided holdE=0. Next cycle the load is no longer in ID/EX and luse drops.
- Flush during holdE is deferred: the bubble is inserted on the first edge with holdE=0. Any number of flushD pulses during the hold collapse into one flush.
- Reset mid-operation: the next edge clears everything including flush_pend and the counters. stallD=0 while the registered state is reset, provided holdE=0.
- All outputs are 0 after reset.

## Test plan
- Reset: assert rst 2 cycles with arbitrary inputs → all outputs 0, validE=0, perf counters 0.
- Bypass: regwriteW=1, rdW=5, resultW=0xDEAD_BEEF, instrD=add $6,$5,$0 → next cycle op1E=0xDEADBEEF (WB_BYPASS=1). With WB_BYPASS=0, op1E holds the old value.
- Load-use: lw $8,0($1) then add $9,$8,$2 → stallD=1 for one cycle, one bubble (validE=0), add issues next cycle, perf_stalls=1.
- Flush under hold: holdE=1 for 3 cycles with a flushD pulse in cycle 1 → ID/EX unchanged for 3 cycles, then one bubble, perf_flushes=1.
- r0/priority: write r0 with 0x1234 → reads 0. Simultaneous flushD and load-use hazard → bubble with stallD=0.
- Saturation: CNT_W=2, hold stallD for 6 cycles → perf_stalls sticks at 3.
